// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage boundaries.
package cpu_pipe_pkg;

  // Stage fill state. FULL is only reachable when the skid entry exists.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Payload widths at each stage boundary.
  localparam int IF_ID_W  = 96;
  localparam int ID_EX_W  = 297;
  localparam int EX_MEM_W = 268;
  localparam int MEM_WB_W = 135;

  // Low payload bits that carry control and are zeroed on a bubble.
  localparam int CTRL_FIELD_W = 9;

  // Entries held for a given state.
  function automatic logic [1:0] occ_of(stage_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between a pipeline stage and its neighbours.
//
// Valid/ready rules: a transfer happens on a rising clk edge where valid and
// ready are both high. A source holding valid keeps valid and data stable
// until the transfer completes; ready may change freely.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Environment side: upstream producer plus downstream consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous reset and a hold enable.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up by one per qualifying cycle, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush, bubble insertion and stall/flush performance counters.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = IF_ID_W,
  parameter int CTRL_W = CTRL_FIELD_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               flush,
  input  logic               bubble,
  pipe_stage_skid_if.slave   bus,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // Ones over the control field; all zero when CTRL_W is 0.
  localparam logic [DATA_W-1:0] CTRL_MASK = (DATA_W'(1) << CTRL_W) - DATA_W'(1);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_c, out_valid_c, full_block;
  logic              accept, pop;
  logic [DATA_W-1:0] in_word;

  // Handshake terms; reset holds both sides idle.
  always_comb begin
    full_block  = 1'b0;
    if (SKID != 0) full_block = (state_q == FULL);
    else           full_block = (state_q != EMPTY) && !bus.out_ready;
    in_ready_c  = !rst && enable && !flush && !full_block;
    out_valid_c = !rst && enable && (state_q != EMPTY);
    accept      = bus.in_valid && in_ready_c;
    pop         = out_valid_c && bus.out_ready;
    in_word     = bubble ? (bus.in_data & ~CTRL_MASK) : bus.in_data;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = main_q;
  assign occupancy     = occ_of(state_q);

  // Next state and data movement; disabled stage holds everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (enable) begin
      if (flush) begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              main_d  = in_word;
            end
          end
          ONE: begin
            if (accept && pop) begin
              main_d = in_word;
            end else if (accept) begin
              state_d = FULL;
              skid_d  = in_word;
            end else if (pop) begin
              state_d = EMPTY;
              main_d  = '0;
            end
          end
          FULL: begin
            if (pop) begin
              state_d = ONE;
              main_d  = skid_q;
              skid_d  = '0;
            end
          end
          default: begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
          end
        endcase
      end
    end
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Stall: upstream offers data the stage cannot take. Flush: entries dropped.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (enable),
    .inc   (bus.in_valid && !in_ready_c),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (enable),
    .inc   (flush && (state_q != EMPTY)),
    .count (flush_cnt)
  );

endmodule
